draw_tom: RTL and testbench
===========================

Name: draw_tom

Overview:
- Consumer of Tom's position: takes the registered tom_x/tom_y coordinates from the Tom position controller and renders Tom's sprite into the VGA pixel stream.
- Sits in the video pipeline between the background/timing stage and the next overlay stage.
- Drives the address of an external synchronous sprite ROM and overlays non-transparent sprite pixels onto rgb_in.
- Delays all timing signals so they stay aligned with rgb_out.

Parameters:
SPRITE_W, 32, sprite width in pixels
SPRITE_H, 48, sprite height in pixels
TRANSP_RGB, 12'hF0F, colour key; ROM pixels equal to this are not drawn
ADDR_W, 11, sprite ROM address width; must be >= clog2(SPRITE_W*SPRITE_H)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-low reset
tom_x  in  10  Tom sprite top-left X (pixels)
tom_y  in  10  Tom sprite top-left Y (pixels)
hcount_in  in  11  horizontal pixel counter
hsync_in  in  1  horizontal sync
hblnk_in  in  1  horizontal blanking
vcount_in  in  11  vertical line counter
vsync_in  in  1  vertical sync
vblnk_in  in  1  vertical blanking
rgb_in  in  12  upstream pixel colour
rom_addr  out  ADDR_W  sprite ROM address (ROM has 1-cycle read latency)
rom_pixel  in  12  sprite ROM data, valid 1 cycle after rom_addr
hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  timing delayed by 3 cycles
rgb_out  out  12  composited pixel

Behaviour:
- Reset (rst=0, async): all outputs 0, including rom_addr and rgb_out. Position latch = (0,0). FSM enters S_ACTIVE. All pipeline valid/in-sprite flags cleared.
- Position latch FSM, two states:
  - S_ACTIVE: on a vblnk_in 0->1 edge (registered previous-vblnk compare), capture tom_x/tom_y into pos_x/pos_y and go to S_BLANK.
  - S_BLANK: on vblnk_in 1->0, return to S_ACTIVE.
  - Position is therefore frame-coherent: tom_x/tom_y changes mid-frame take effect only at the next vblank start.
- Stage 1 (edge t+1):
  - in_spr = !hblnk_in && !vblnk_in && hcount_in >= pos_x && hcount_in < pos_x+SPRITE_W && vcount_in >= pos_y && vcount_in < pos_y+SPRITE_H.
  - All compares use 12-bit zero-extended arithmetic, so pos_x+SPRITE_W never wraps.
  - rom_addr <= (vcount_in-pos_y)*SPRITE_W + (hcount_in-pos_x) when in_spr, else rom_addr holds its previous value.
  - Timing and rgb_in are captured into delay stage 1.
- Stage 2 (edge t+2): ROM presents rom_pixel; in_spr, timing and rgb are delayed one more stage.
- Stage 3 (edge t+3):
  - rgb_out <= (in_spr_d2 && rom_pixel != TRANSP_RGB) ? rom_pixel : rgb_d2.
  - Timing outputs <= stage-2 copies.
- Total latency from any input to the aligned outputs is 3 cycles.
- Clipping: sprite columns beyond the active area are never visible because blanking forces in_spr=0. Sprite rows/columns never wrap to hcount=0 or vcount=0.
- Blanking always passes rgb_in through unchanged.
- Reset mid-frame: pipeline flushed to 0 and position returns to (0,0) until the next vblank edge.

Optional Feature:
- Macro: TOM_MIRROR_EN.
- Defined: adds input port mirror (1 bit), latched into the position latch at the same vblank edge as pos_x/pos_y. When the latched value is 1, the column term becomes SPRITE_W-1-(hcount_in-pos_x), so Tom faces left.
- Undefined: no mirror port; column term is always hcount_in-pos_x.

Test Plan:
- Reset held low for 5 cycles -> all outputs 0. Release, drive a blank frame -> rgb_out equals rgb_in delayed 3 cycles, and timing outputs equal timing inputs delayed 3 cycles.
- tom=(50,50) latched at vblank, ROM returns 12'h123 at addr 0 -> at hcount=50, vcount=50: rom_addr=0 at t+1, rgb_out=12'h123 at t+3. At hcount=81, vcount=97: rom_addr=1535.
- ROM returns 12'hF0F inside the sprite, rgb_in=12'h0A0 -> rgb_out=12'h0A0.
- tom_x changed 50->200 at vcount=300 mid-frame -> rest of frame still draws at x=50; next frame draws at x=200.
- tom=(790,590) -> drawn only at hcount 790..799, vcount 590..599; hcount 0..21 and vcount 0..37 of the following line/frame show rgb_in (no wrap).
- Reset asserted at vcount=60 inside the sprite -> outputs 0 immediately; after release, sprite appears at (0,0) in the first frame and at tom_x/tom_y after the next vblank. With TOM_MIRROR_EN and mirror=1: hcount=pos_x -> rom_addr=31 on row 0.

Source files
------------

// File: rtl/draw_tom.sv
// draw_tom: overlays Tom's sprite on the pixel stream; position is latched at vblank start (TOM_MIRROR_EN adds a horizontal-flip input).
// Latency: 3 clk from any input to rgb_out and the delayed timing outputs; sprite ROM read is 1 clk.
// Backpressure: none, free-running pixel pipeline that accepts one pixel every clock.
module draw_tom #(
    parameter int          SPRITE_W   = 32,
    parameter int          SPRITE_H   = 48,
    parameter logic [11:0] TRANSP_RGB = 12'hF0F,
    parameter int          ADDR_W     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        tom_x,
    input  logic [9:0]        tom_y,
`ifdef TOM_MIRROR_EN
    input  logic              mirror,
`endif
    input  logic [10:0]       hcount_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic [10:0]       vcount_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_pixel,
    output logic [10:0]       hcount_out,
    output logic              hsync_out,
    output logic              hblnk_out,
    output logic [10:0]       vcount_out,
    output logic              vsync_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out
);

    typedef enum logic {S_ACTIVE, S_BLANK} state_t;

    state_t      state, state_nxt;
    logic        vblnk_prev;
    logic        latch_pos;
    logic [9:0]  pos_x, pos_y;
`ifdef TOM_MIRROR_EN
    logic        mirror_q;
`endif

    // Stage 1 geometry, done in 12 bits so pos + size never wraps
    logic [11:0]       hx, vy, px, py, col, row, col_term;
    logic              in_spr;
    logic [ADDR_W-1:0] addr_nxt;

    // Delay-line registers
    logic        in_spr_d1, in_spr_d2;
    logic [10:0] hcount_d1, hcount_d2, vcount_d1, vcount_d2;
    logic        hsync_d1, hsync_d2, hblnk_d1, hblnk_d2;
    logic        vsync_d1, vsync_d2, vblnk_d1, vblnk_d2;
    logic [11:0] rgb_d1, rgb_d2;

    // FSM state, vblank history and frame-coherent position latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_ACTIVE;
            vblnk_prev <= 1'b0;
            pos_x      <= '0;
            pos_y      <= '0;
`ifdef TOM_MIRROR_EN
            mirror_q   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            vblnk_prev <= vblnk_in;
            if (latch_pos) begin
                pos_x    <= tom_x;
                pos_y    <= tom_y;
`ifdef TOM_MIRROR_EN
                mirror_q <= mirror;
`endif
            end
        end
    end

    // Next state: capture position on vblank rise, re-arm on vblank fall
    always_comb begin
        state_nxt = state;
        latch_pos = 1'b0;
        case (state)
            S_ACTIVE: begin
                if (vblnk_in && !vblnk_prev) begin
                    latch_pos = 1'b1;
                    state_nxt = S_BLANK;
                end
            end
            S_BLANK: begin
                if (!vblnk_in && vblnk_prev) begin
                    state_nxt = S_ACTIVE;
                end
            end
            default: state_nxt = S_ACTIVE;
        endcase
    end

    // Sprite hit test and ROM address for the current pixel
    always_comb begin
        hx       = {1'b0, hcount_in};
        vy       = {1'b0, vcount_in};
        px       = {2'b00, pos_x};
        py       = {2'b00, pos_y};
        col      = hx - px;
        row      = vy - py;
        in_spr   = !hblnk_in && !vblnk_in &&
                   (hx >= px) && (hx < px + 12'(SPRITE_W)) &&
                   (vy >= py) && (vy < py + 12'(SPRITE_H));
        col_term = col;
`ifdef TOM_MIRROR_EN
        if (mirror_q) begin
            col_term = 12'(SPRITE_W - 1) - col;
        end
`endif
        addr_nxt = ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col_term);
    end

    // Three-stage pixel pipeline: address/capture, ROM wait, composite
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr   <= '0;
            in_spr_d1  <= 1'b0;
            in_spr_d2  <= 1'b0;
            hcount_d1  <= '0;
            hcount_d2  <= '0;
            vcount_d1  <= '0;
            vcount_d2  <= '0;
            hsync_d1   <= 1'b0;
            hsync_d2   <= 1'b0;
            hblnk_d1   <= 1'b0;
            hblnk_d2   <= 1'b0;
            vsync_d1   <= 1'b0;
            vsync_d2   <= 1'b0;
            vblnk_d1   <= 1'b0;
            vblnk_d2   <= 1'b0;
            rgb_d1     <= '0;
            rgb_d2     <= '0;
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            if (in_spr) begin
                rom_addr <= addr_nxt;
            end
            in_spr_d1  <= in_spr;
            hcount_d1  <= hcount_in;
            vcount_d1  <= vcount_in;
            hsync_d1   <= hsync_in;
            hblnk_d1   <= hblnk_in;
            vsync_d1   <= vsync_in;
            vblnk_d1   <= vblnk_in;
            rgb_d1     <= rgb_in;

            in_spr_d2  <= in_spr_d1;
            hcount_d2  <= hcount_d1;
            vcount_d2  <= vcount_d1;
            hsync_d2   <= hsync_d1;
            hblnk_d2   <= hblnk_d1;
            vsync_d2   <= vsync_d1;
            vblnk_d2   <= vblnk_d1;
            rgb_d2     <= rgb_d1;

            hcount_out <= hcount_d2;
            vcount_out <= vcount_d2;
            hsync_out  <= hsync_d2;
            hblnk_out  <= hblnk_d2;
            vsync_out  <= vsync_d2;
            vblnk_out  <= vblnk_d2;
            rgb_out    <= (in_spr_d2 && (rom_pixel != TRANSP_RGB)) ? rom_pixel : rgb_d2;
        end
    end

endmodule

// File: tb/tb_draw_tom.sv
// tb_draw_tom: directed vector bench for draw_tom with a 1-cycle synchronous sprite ROM model.
// Latency: each vector checks rom_addr one clock and rgb_out/timing three clocks after it is applied.
// Backpressure: none; the bench drives one pixel per clock.
module tb_draw_tom;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  tom_x, tom_y;
`ifdef TOM_MIRROR_EN
    logic        mirror = 1'b0;
`endif
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] rom_addr;
    logic [11:0] rom_pixel = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    draw_tom dut (
        .clk        (clk),
        .rst        (rst),
        .tom_x      (tom_x),
        .tom_y      (tom_y),
`ifdef TOM_MIRROR_EN
        .mirror     (mirror),
`endif
        .hcount_in  (hcount_in),
        .hsync_in   (hsync_in),
        .hblnk_in   (hblnk_in),
        .vcount_in  (vcount_in),
        .vsync_in   (vsync_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .rom_addr   (rom_addr),
        .rom_pixel  (rom_pixel),
        .hcount_out (hcount_out),
        .hsync_out  (hsync_out),
        .hblnk_out  (hblnk_out),
        .vcount_out (vcount_out),
        .vsync_out  (vsync_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    // Sprite ROM: address 0 -> 0x123, address 7 -> colour key, else {1, addr}
    function automatic logic [11:0] rom_val(input logic [10:0] a);
        if (a == 11'd0)      return 12'h123;
        else if (a == 11'd7) return 12'hF0F;
        else                 return {1'b1, a};
    endfunction

    // Synchronous ROM read, one clock of latency
    always_ff @(posedge clk) begin
        rom_pixel <= rom_val(rom_addr);
    end

    typedef struct {
        logic        latch;
        logic [9:0]  tx, ty;
        logic [10:0] h, v;
        logic        hb, vb;
        logic [11:0] rgb;
        logic [10:0] exp_addr;
        logic [11:0] exp_rgb;
    } vec_t;

    function automatic vec_t mk(input logic latch, input logic [9:0] tx, input logic [9:0] ty,
                                input logic [10:0] h, input logic [10:0] v, input logic hb,
                                input logic vb, input logic [11:0] rgb,
                                input logic [10:0] exp_addr, input logic [11:0] exp_rgb);
        vec_t r;
        r.latch = latch; r.tx = tx; r.ty = ty; r.h = h; r.v = v; r.hb = hb; r.vb = vb;
        r.rgb = rgb; r.exp_addr = exp_addr; r.exp_rgb = exp_rgb;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Vblank pulse with new position on tom_x/tom_y; entered and left at #1 after an edge
    task automatic vblank_pulse(input logic [9:0] tx, input logic [9:0] ty);
        tom_x = tx;
        tom_y = ty;
        hblnk_in = 1'b1;
        vblnk_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vblnk_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One pixel, then blanking idle; rom_addr checked at t+1, outputs at t+3
    task automatic apply_vec(input string name, input vec_t t);
        if (t.latch) vblank_pulse(t.tx, t.ty);
        tom_x     = t.tx;
        tom_y     = t.ty;
        hcount_in = t.h;
        vcount_in = t.v;
        hsync_in  = t.h[0];
        vsync_in  = t.v[0];
        hblnk_in  = t.hb;
        vblnk_in  = t.vb;
        rgb_in    = t.rgb;
        @(posedge clk);
        #1;
        check({name, ".rom_addr"}, 32'(rom_addr), 32'(t.exp_addr));
        hblnk_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check({name, ".rgb_out"}, 32'(rgb_out), 32'(t.exp_rgb));
        check({name, ".timing"},
              32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}),
              32'({t.h, t.h[0], t.hb, t.v, t.v[0], t.vb}));
    endtask

    vec_t        vecs[20];
    logic [10:0] bh[8], bv[8];
    logic        bhs[8], bvs[8];
    logic [11:0] brgb[8];

    initial begin
        // Sprite at (50,50): corners, colour key, each out-of-box side, blanking
        vecs[0]  = mk(1, 50, 50,  50, 50, 0, 0, 12'h0A0,    0, 12'h123);
        vecs[1]  = mk(0, 50, 50,  81, 97, 0, 0, 12'h0A0, 1535, 12'hDFF);
        vecs[2]  = mk(0, 50, 50,  57, 50, 0, 0, 12'h0A0,    7, 12'h0A0);
        vecs[3]  = mk(0, 50, 50,  49, 50, 0, 0, 12'h0AB,    7, 12'h0AB);
        vecs[4]  = mk(0, 50, 50,  82, 60, 0, 0, 12'h0AC,    7, 12'h0AC);
        vecs[5]  = mk(0, 50, 50,  60, 98, 0, 0, 12'h0AD,    7, 12'h0AD);
        vecs[6]  = mk(0, 50, 50,  60, 60, 1, 0, 12'h0AE,    7, 12'h0AE);
        vecs[7]  = mk(0, 50, 50,  60, 55, 0, 0, 12'h0AF,  170, 12'h8AA);
        vecs[8]  = mk(0, 50, 50,  50, 49, 0, 0, 12'h111,  170, 12'h111);
        // tom_x moves to 200 mid-frame: old position holds until next vblank
        vecs[9]  = mk(0, 200, 50,  50, 60, 0, 0, 12'h222, 320, 12'h940);
        vecs[10] = mk(0, 200, 50, 200, 60, 0, 0, 12'h223, 320, 12'h223);
        vecs[11] = mk(1, 200, 50, 201, 61, 0, 0, 12'h224, 353, 12'h961);
        vecs[12] = mk(0, 200, 50,  51, 61, 0, 0, 12'h225, 353, 12'h225);
        // Bottom-right corner: no wrap to column/row 0, blanking clips
        vecs[13] = mk(1, 790, 590, 790, 590, 0, 0, 12'h333,   0, 12'h123);
        vecs[14] = mk(0, 790, 590, 799, 599, 0, 0, 12'h333, 297, 12'h929);
        vecs[15] = mk(0, 790, 590,   0, 599, 0, 0, 12'h334, 297, 12'h334);
        vecs[16] = mk(0, 790, 590,  21, 590, 0, 0, 12'h335, 297, 12'h335);
        vecs[17] = mk(0, 790, 590, 799,  37, 0, 0, 12'h336, 297, 12'h336);
        vecs[18] = mk(0, 790, 590, 810, 600, 1, 0, 12'h337, 297, 12'h337);
        vecs[19] = mk(0, 790, 590, 795,   0, 0, 0, 12'h338, 297, 12'h338);

        // Reset held for 5 clocks with busy inputs
        tom_x = 10'd5; tom_y = 10'd5;
        hcount_in = 11'd5; vcount_in = 11'd5;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = 12'hABC;
        repeat (5) @(posedge clk);
        #1;
        check("reset.rom_addr", 32'(rom_addr), 32'd0);
        check("reset.rgb_out", 32'(rgb_out), 32'd0);
        check("reset.timing",
              32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}), 32'd0);

        // Blank frame: everything passes through 3 clocks late
        tom_x = 10'd0; tom_y = 10'd0;
        rst = 1'b1;
        for (int e = 0; e < 10; e++) begin
            if (e < 8) begin
                bh[e] = 11'(e * 37 + 3);
                bv[e] = 11'(600 + e);
                bhs[e] = e[0];
                bvs[e] = e[1];
                brgb[e] = 12'(e * 12'h111 + 1);
                hcount_in = bh[e]; vcount_in = bv[e];
                hsync_in = bhs[e]; vsync_in = bvs[e];
                hblnk_in = 1'b1; vblnk_in = 1'b1;
                rgb_in = brgb[e];
            end
            @(posedge clk);
            #1;
            if (e >= 2) begin
                check("blank.rgb_out", 32'(rgb_out), 32'(brgb[e-2]));
                check("blank.timing",
                      32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}),
                      32'({bh[e-2], bhs[e-2], 1'b1, bv[e-2], bvs[e-2], 1'b1}));
            end
        end
        vblnk_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            apply_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset mid-sprite: outputs clear at once, position falls back to (0,0)
        vblank_pulse(10'd50, 10'd50);
        hcount_in = 11'd60; vcount_in = 11'd60; hsync_in = 1'b0; vsync_in = 1'b0;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'h444;
        repeat (3) @(posedge clk);
        #1;
        check("prereset.rgb_out", 32'(rgb_out), 32'h94A);
        #2;
        rst = 1'b0;
        #1;
        check("midreset.rgb_out", 32'(rgb_out), 32'd0);
        check("midreset.rom_addr", 32'(rom_addr), 32'd0);
        check("midreset.timing",
              32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply_vec("post0", mk(0, 100, 100,   0,   0, 0, 0, 12'h555,  0, 12'h123));
        apply_vec("post1", mk(0, 100, 100, 101, 101, 0, 0, 12'h556,  0, 12'h556));
        apply_vec("post2", mk(1, 100, 100, 101, 101, 0, 0, 12'h557, 33, 12'h821));

`ifdef TOM_MIRROR_EN
        // Mirrored sprite: leftmost screen column reads the last ROM column
        mirror = 1'b1;
        apply_vec("mirror0", mk(1, 50, 50, 50, 50, 0, 0, 12'h666, 31, 12'h81F));
        apply_vec("mirror1", mk(0, 50, 50, 81, 50, 0, 0, 12'h667,  0, 12'h123));
        mirror = 1'b0;
        apply_vec("mirror2", mk(1, 50, 50, 50, 50, 0, 0, 12'h668,  0, 12'h123));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
